// File: rtl/systolic_fir_array_if.sv
// -----------------------------------------------------------------------------
// systolic_fir_array_if
// Bundle of the control, sample, coefficient and result signals of the
// systolic FIR filter. Clock and reset are kept outside the bundle.
//
// Signals
//   enable     global advance, 0 stalls the whole filter
//   clear      synchronous flush of sample history and result pipeline
//   valid_in   x_in carries a sample this cycle
//   x_in       input sample (unsigned, DATA_WIDTH)
//   coef_wr    write coef_data to tap h[coef_idx]
//   coef_data  coefficient value (unsigned, DATA_WIDTH)
//   coef_idx   next tap index to be written
//   coef_done  one-cycle pulse after the last tap has been written
//   valid_out  y_out holds a new result this cycle
//   y_out      filter result (ACC_WIDTH)
//
// Modports
//   master  drives the inputs of the filter (stimulus side)
//   slave   the filter itself
// -----------------------------------------------------------------------------
interface systolic_fir_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS)
) ();

  logic                     enable;
  logic                     clear;
  logic                     valid_in;
  logic [DATA_WIDTH-1:0]    x_in;
  logic                     coef_wr;
  logic [DATA_WIDTH-1:0]    coef_data;
  logic [$clog2(TAPS)-1:0]  coef_idx;
  logic                     coef_done;
  logic                     valid_out;
  logic [ACC_WIDTH-1:0]     y_out;

  modport master (
    output enable, clear, valid_in, x_in, coef_wr, coef_data,
    input  coef_idx, coef_done, valid_out, y_out
  );

  modport slave (
    input  enable, clear, valid_in, x_in, coef_wr, coef_data,
    output coef_idx, coef_done, valid_out, y_out
  );

endinterface

// File: rtl/systolic_fir_array.sv
// -----------------------------------------------------------------------------
// systolic_fir_array
// Unsigned FIR filter y[n] = sum_k h[k] * x[n-k], n counting accepted samples.
//
// Architecture
//   On the acceptance edge every tap product is formed from the new sample,
//   the sample history and the coefficients valid at that moment, so later
//   coefficient writes never disturb results already in flight. The products
//   then march through a systolic adder chain: stage s adds one more product
//   to the running sum and hands the remaining products on, shifted by one.
//   After TAPS-1 adder stages an output register presents the result, giving
//   a latency of TAPS+1 enabled cycles from acceptance to valid_out.
//
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    systolic_fir_array_if.slave (enable, clear, valid_in, x_in,
//          coef_wr, coef_data, coef_idx, coef_done, valid_out, y_out)
//
// Build option
//   FIR_SAT_OUT_EN  when defined, y_out is clamped to 2^DATA_WIDTH-1.
//                   Latency and valid timing are identical either way.
// -----------------------------------------------------------------------------
module systolic_fir_array #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS)
) (
  input logic                 clk,
  input logic                 reset,
  systolic_fir_array_if.slave bus
);

  localparam int              IDX_W    = $clog2(TAPS);
  // number of tap products that still have to be added after stage 0
  localparam int              NPS      = TAPS - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  // Unsigned product evaluated at the full result width.
  function automatic logic [ACC_WIDTH-1:0] mul_u(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return ACC_WIDTH'(a) * ACC_WIDTH'(b);
  endfunction

`ifdef FIR_SAT_OUT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({DATA_WIDTH{1'b1}});

  // Clamp the full-precision sum to the sample range.
  function automatic logic [ACC_WIDTH-1:0] shape_out(input logic [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction
`else
  // Full-precision sum passes through unchanged.
  function automatic logic [ACC_WIDTH-1:0] shape_out(input logic [ACC_WIDTH-1:0] v);
    return v;
  endfunction
`endif

  // coefficient bank and write pointer
  logic [DATA_WIDTH-1:0] h_q    [TAPS];
  logic [DATA_WIDTH-1:0] h_d    [TAPS];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;

  // hist_q[j] holds x[n-1-j]; the newest sample comes straight from x_in
  logic [DATA_WIDTH-1:0] hist_q [NPS];
  logic [DATA_WIDTH-1:0] hist_d [NPS];

  // systolic pipeline: running sums, pending products, valid flags
  logic [ACC_WIDTH-1:0]  acc_q  [TAPS];
  logic [ACC_WIDTH-1:0]  acc_d  [TAPS];
  logic [ACC_WIDTH-1:0]  ps_q   [NPS][NPS];
  logic [ACC_WIDTH-1:0]  ps_d   [NPS][NPS];
  logic [TAPS-1:0]       vld_q, vld_d;

  // output registers
  logic                  vout_q, vout_d;
  logic [ACC_WIDTH-1:0]  y_q, y_d;

  logic                  accept_s;
  logic                  flush_s;

  // clear wins over valid_in; nothing happens without enable
  assign accept_s = bus.enable & bus.valid_in & ~bus.clear;
  assign flush_s  = bus.enable & bus.clear;

  // Coefficient write pointer, bank update and last-tap pulse.
  always_comb begin
    h_d    = h_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (bus.enable && bus.coef_wr) begin
      h_d[idx_q] = bus.coef_data;
      if (idx_q == LAST_IDX) begin
        idx_d  = {IDX_W{1'b0}};
        done_d = 1'b1;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        done_d = 1'b0;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Sample history: shifts only on acceptance, zeroed by clear.
  always_comb begin
    hist_d = hist_q;
    if (flush_s) begin
      for (int j = 0; j < NPS; j++) begin
        hist_d[j] = {DATA_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      hist_d[0] = bus.x_in;
      for (int j = 1; j < NPS; j++) begin
        hist_d[j] = hist_q[j-1];
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Product capture and systolic accumulation, frozen while enable is low.
  always_comb begin
    acc_d = acc_q;
    ps_d  = ps_q;
    vld_d = vld_q;
    if (bus.enable) begin
      // stage 0: all products use the coefficients in force before this edge
      vld_d[0] = accept_s;
      acc_d[0] = mul_u(h_q[0], bus.x_in);
      for (int j = 0; j < NPS; j++) begin
        ps_d[0][j] = mul_u(h_q[j+1], hist_q[j]);
      end
      // stages 1..TAPS-1: add the head product, pass the rest down one slot
      for (int s = 1; s < TAPS; s++) begin
        vld_d[s] = flush_s ? 1'b0 : vld_q[s-1];
        acc_d[s] = acc_q[s-1] + ps_q[s-1][0];
      end
      for (int s = 1; s < NPS; s++) begin
        for (int j = 0; j < NPS - 1; j++) begin
          ps_d[s][j] = ps_q[s-1][j+1];
        end
        ps_d[s][NPS-1] = {ACC_WIDTH{1'b0}};
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Output stage: a stall or clear blanks valid_out, y_out only moves on a result.
  always_comb begin
    vout_d = 1'b0;
    y_d    = y_q;
    if (bus.enable && !bus.clear && vld_q[TAPS-1]) begin
      vout_d = 1'b1;
      y_d    = shape_out(acc_q[TAPS-1]);
    end else begin
      vout_d = 1'b0;
      y_d    = y_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        h_q[k]   <= {DATA_WIDTH{1'b0}};
        acc_q[k] <= {ACC_WIDTH{1'b0}};
      end
      for (int j = 0; j < NPS; j++) begin
        hist_q[j] <= {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NPS; i++) begin
          ps_q[j][i] <= {ACC_WIDTH{1'b0}};
        end
      end
      idx_q  <= {IDX_W{1'b0}};
      done_q <= 1'b0;
      vld_q  <= {TAPS{1'b0}};
      vout_q <= 1'b0;
      y_q    <= {ACC_WIDTH{1'b0}};
    end else begin
      h_q    <= h_d;
      acc_q  <= acc_d;
      hist_q <= hist_d;
      ps_q   <= ps_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      vld_q  <= vld_d;
      vout_q <= vout_d;
      y_q    <= y_d;
    end
  end

  assign bus.coef_idx  = idx_q;
  assign bus.coef_done = done_q;
  assign bus.valid_out = vout_q;
  assign bus.y_out     = y_q;

endmodule

// File: tb/tb_systolic_fir_array.sv
// -----------------------------------------------------------------------------
// tb_systolic_fir_array
// Self-checking bench for systolic_fir_array (DATA_WIDTH=8, TAPS=4).
// A behavioural model (sample list, pending-result list with remaining
// enabled-cycle counts) predicts every output each cycle; directed tables and
// hand-written sequences add fixed expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_systolic_fir_array;

  localparam int DW  = 8;
  localparam int NT  = 4;
  localparam int AW  = 2 * DW + $clog2(NT);

  logic clk;
  logic reset;

  systolic_fir_array_if #(.DATA_WIDTH(DW), .TAPS(NT), .ACC_WIDTH(AW)) bus ();

  systolic_fir_array #(.DATA_WIDTH(DW), .TAPS(NT), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_h [NT];
  int m_idx;
  int m_hist [$];   // accepted samples, newest first
  int p_cnt  [$];   // enabled edges left before each pending result appears
  int p_y    [$];
  int m_y;
  bit m_v;
  bit m_done;

  int pulse_cnt;
  int last_y;

  typedef struct {
    bit en; bit clr; bit vin; int x; bit cw; int cd; bit ev; int ey;
  } vec_t;
  vec_t tbl [$];

  function automatic int sat_y(input int v);
`ifdef FIR_SAT_OUT_EN
    return (v > 255) ? 255 : v;
`else
    return v;
`endif
  endfunction

  function automatic void row(input bit en, input bit clr, input bit vin, input int x,
                              input bit cw, input int cd, input bit ev, input int ey);
    vec_t r;
    r = '{en, clr, vin, x, cw, cd, ev, ey};
    tbl.push_back(r);
  endfunction

  function automatic void load_rows(input int a, input int b, input int c, input int d, input int ey);
    row(1, 0, 0, 0, 1, a, 0, ey);
    row(1, 0, 0, 0, 1, b, 0, ey);
    row(1, 0, 0, 0, 1, c, 0, ey);
    row(1, 0, 0, 0, 1, d, 0, ey);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) m_h[k] = 0;
    m_idx = 0;
    m_hist.delete();
    p_cnt.delete();
    p_y.delete();
    m_y = 0;
    m_v = 0;
    m_done = 0;
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic step(input bit en, input bit clr, input bit vin, input int x,
                      input bit cw, input int cd);
    int ysum;
    bit emit;
    bit done_n;
    bus.enable    = en;
    bus.clear     = clr;
    bus.valid_in  = vin;
    bus.x_in      = 8'(x);
    bus.coef_wr   = cw;
    bus.coef_data = 8'(cd);
    emit   = 0;
    done_n = 0;
    if (en) begin
      if (clr) begin
        m_hist.delete();
        p_cnt.delete();
        p_y.delete();
      end else begin
        for (int i = 0; i < p_cnt.size(); i++) p_cnt[i] = p_cnt[i] - 1;
        if (p_cnt.size() > 0 && p_cnt[0] == 0) begin
          emit = 1;
          m_y  = sat_y(p_y[0]);
          void'(p_cnt.pop_front());
          void'(p_y.pop_front());
        end
        if (vin) begin
          m_hist.push_front(x);
          if (m_hist.size() > NT) void'(m_hist.pop_back());
          ysum = 0;
          for (int k = 0; k < m_hist.size(); k++) ysum += m_h[k] * m_hist[k];
          p_cnt.push_back(NT);   // acceptance edge already counted
          p_y.push_back(ysum);
        end
      end
      if (cw) begin
        m_h[m_idx] = cd;
        done_n = (m_idx == NT - 1);
        m_idx = (m_idx + 1) % NT;
      end
    end
    m_v    = emit;
    m_done = done_n;
    @(posedge clk);
    #1;
    chk("valid_out", bus.valid_out, m_v);
    chk("y_out", bus.y_out, m_y);
    chk("coef_idx", bus.coef_idx, m_idx);
    chk("coef_done", bus.coef_done, m_done);
    if (bus.valid_out === 1'b1) begin
      pulse_cnt++;
      last_y = bus.y_out;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int a, input int b, input int c, input int d);
    step(1, 0, 0, 0, 1, a);
    step(1, 0, 0, 0, 1, b);
    step(1, 0, 0, 0, 1, c);
    step(1, 0, 0, 0, 1, d);
  endtask

  task automatic apply_reset(input int ncyc);
    bus.enable = 0; bus.clear = 0; bus.valid_in = 0; bus.x_in = '0;
    bus.coef_wr = 0; bus.coef_data = '0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_y_out", bus.y_out, 0);
    chk("rst_coef_idx", bus.coef_idx, 0);
    chk("rst_coef_done", bus.coef_done, 0);
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_hold_valid_out", bus.valid_out, 0);
    chk("rst_hold_y_out", bus.y_out, 0);
    reset = 1'b0;
  endtask

  initial begin
    int yb;
    pulse_cnt = 0;
    last_y    = 0;
    apply_reset(3);

    // ---- directed table: impulse, max input, bubbles + stall ----
    load_rows(1, 2, 3, 4, 0);
    row(1, 0, 1, 1, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 0, 1, 1);   // fifth cycle after acceptance
    row(1, 0, 0, 0, 0, 0, 1, 2);
    row(1, 0, 0, 0, 0, 0, 1, 3);
    row(1, 0, 0, 0, 0, 0, 1, 4);
    row(1, 0, 0, 0, 0, 0, 0, 4);

    row(1, 1, 0, 0, 0, 0, 0, 4);
    load_rows(255, 255, 255, 255, 4);
    for (int i = 0; i < 4; i++) row(1, 0, 1, 255, 0, 0, 0, 4);
    row(1, 0, 0, 0, 0, 0, 1, sat_y(65025));
    row(1, 0, 0, 0, 0, 0, 1, sat_y(130050));
    row(1, 0, 0, 0, 0, 0, 1, sat_y(195075));
    row(1, 0, 0, 0, 0, 0, 1, sat_y(260100));
    row(1, 0, 0, 0, 0, 0, 0, sat_y(260100));

    yb = sat_y(260100);
    row(1, 1, 0, 0, 0, 0, 0, yb);
    load_rows(1, 2, 3, 4, yb);
    row(1, 0, 1, 1, 0, 0, 0, yb);
    row(1, 0, 0, 0, 0, 0, 0, yb);
    row(1, 0, 1, 2, 0, 0, 0, yb);
    row(0, 0, 0, 0, 0, 0, 0, yb);
    row(0, 0, 0, 0, 0, 0, 0, yb);
    row(0, 0, 0, 0, 0, 0, 0, yb);
    row(1, 0, 0, 0, 0, 0, 0, yb);
    row(1, 0, 0, 0, 0, 0, 1, 1);
    row(1, 0, 0, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 1, 4);
    row(1, 0, 0, 0, 0, 0, 0, 4);

    pulse_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].vin, tbl[i].x, tbl[i].cw, tbl[i].cd);
      chk($sformatf("tbl%0d_valid", i), bus.valid_out, tbl[i].ev);
      chk($sformatf("tbl%0d_y", i), bus.y_out, tbl[i].ey);
    end
    chk("tbl_total_pulses", pulse_cnt, 10);

    // ---- coefficient wrap ----
    step(1, 0, 0, 0, 1, 5);
    step(1, 0, 0, 0, 1, 6);
    step(1, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 1, 8);
    chk("wrap_done_4th", bus.coef_done, 1);
    chk("wrap_idx_4th", bus.coef_idx, 0);
    step(1, 0, 0, 0, 1, 9);
    chk("wrap_done_5th", bus.coef_done, 0);
    chk("wrap_idx_5th", bus.coef_idx, 1);
    step(1, 1, 0, 0, 0, 0);
    pulse_cnt = 0;
    step(1, 0, 1, 1, 0, 0);
    idle(6);
    chk("wrap_pulses", pulse_cnt, 1);
    chk("wrap_h0_result", last_y, sat_y(9));
    load(2, 3, 4, 1);   // pointer sits at 1, so this restores h = {1,2,3,4}

    // ---- clear mid-stream ----
    pulse_cnt = 0;
    step(1, 0, 1, 3, 0, 0);
    step(1, 0, 1, 5, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 0, 0);
    idle(7);
    chk("clear_pulses", pulse_cnt, 1);
    chk("clear_result", last_y, 2);

    // ---- reset mid-stream ----
    step(1, 0, 1, 7, 0, 0);
    step(1, 0, 1, 9, 0, 0);
    idle(1);
    apply_reset(2);
    pulse_cnt = 0;
    load(1, 2, 3, 4);
    step(1, 0, 1, 2, 0, 0);
    idle(7);
    chk("reset_pulses", pulse_cnt, 1);
    chk("reset_result", last_y, 2);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 6, int'($urandom_range(0, 255)),
           $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
